// File: rtl/heap_array_allocator.sv
// heap_array_allocator
//   Shared allocator for heap array handles. Round-robin arbitration between
//   NRequesters units issuing alloc/free requests. It owns the high-water
//   allocation counter, a LIFO stack of freed indices and a per-array live
//   bitmap. Each operation takes three cycles (IDLE -> EXEC -> DONE).
//
// Ports
//   clock, reset      clock; synchronous active-high reset
//   req_alloc[N]      per-requester allocate request, held until grant
//   req_free[N]       per-requester free request, held until grant
//   free_index[N*W]   index to free; requester i uses bits [i*W +: W]
//   grant[N]          one-cycle one-hot pulse to the served requester
//   resp_valid        one-cycle pulse, coincident with grant
//   resp_index[W]     allocated / echoed index (0 on alloc error)
//   resp_error        operation rejected (valid with resp_valid)
//   size_clr_valid    pulse: clear arraySizes[size_clr_index]
//   size_clr_index[W] array-size entry to clear
//   allocs[W]         arrays ever handed out fresh (high-water mark)
//   in_use[W]         current live array count
module heap_array_allocator #(
    parameter int MemoryElementWidth = 12,
    parameter int NArrays            = 4,
    parameter int NRequesters        = 2
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NRequesters-1:0]                    req_alloc,
    input  logic [NRequesters-1:0]                    req_free,
    input  logic [NRequesters*MemoryElementWidth-1:0] free_index,
    output logic [NRequesters-1:0]                    grant,
    output logic                                      resp_valid,
    output logic [MemoryElementWidth-1:0]             resp_index,
    output logic                                      resp_error,
    output logic                                      size_clr_valid,
    output logic [MemoryElementWidth-1:0]             size_clr_index,
    output logic [MemoryElementWidth-1:0]             allocs,
    output logic [MemoryElementWidth-1:0]             in_use
);
    localparam int W  = MemoryElementWidth;
    localparam int N  = NRequesters;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(NArrays + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_ALLOC, OP_FREE, OP_BOTH} op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [RW-1:0]        winner_q, winner_d;
    logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [W-1:0]         idx_q, idx_d;
    logic [W-1:0]         allocs_q, allocs_d;
    logic [W-1:0]         in_use_q, in_use_d;
    logic [NArrays-1:0]   live_q, live_d;
    logic [W-1:0]         stack_q [NArrays];
    logic [W-1:0]         stack_d [NArrays];
    logic [TW-1:0]        top_q, top_d;
    logic [N-1:0]         grant_q, grant_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [W-1:0]         resp_index_q, resp_index_d;
    logic                 resp_error_q, resp_error_d;
    logic                 size_clr_valid_q, size_clr_valid_d;
    logic [W-1:0]         size_clr_index_q, size_clr_index_d;

    logic [N-1:0]         pending;
    logic                 found;
    logic [RW-1:0]        win;
    logic                 live_hit;
    logic [W-1:0]         top_val;
    logic [W-1:0]         new_idx;

    assign pending = req_alloc | req_free;

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        winner_d         = winner_q;
        rr_ptr_d         = rr_ptr_q;
        idx_d            = idx_q;
        allocs_d         = allocs_q;
        in_use_d         = in_use_q;
        live_d           = live_q;
        stack_d          = stack_q;
        top_d            = top_q;
        grant_d          = grant_q;
        resp_valid_d     = resp_valid_q;
        resp_index_d     = resp_index_q;
        resp_error_d     = resp_error_q;
        size_clr_valid_d = size_clr_valid_q;
        size_clr_index_d = size_clr_index_q;

        // First pending requester scanning upward from rr_ptr (wrapping).
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < N; off++) begin
            int cand;
            cand = (int'(rr_ptr_q) + off) % N;
            if (!found && pending[cand]) begin
                found = 1'b1;
                win   = RW'(cand);
            end
        end

        // Live bit of the latched free index and the current stack top;
        // loops keep every index into the small arrays in range.
        live_hit = 1'b0;
        top_val  = '0;
        for (int j = 0; j < NArrays; j++) begin
            if (idx_q == W'(j))        live_hit = live_q[j];
            if (top_q == TW'(j + 1))   top_val  = stack_q[j];
        end
        new_idx = (top_q != '0) ? top_val : allocs_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d = win;
                    idx_d    = free_index[int'(win)*W +: W];
                    if (req_alloc[win] && req_free[win]) op_d = OP_BOTH;
                    else if (req_alloc[win])             op_d = OP_ALLOC;
                    else                                 op_d = OP_FREE;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                grant_d           = '0;
                grant_d[winner_q] = 1'b1;
                resp_valid_d      = 1'b1;
                resp_error_d      = 1'b0;
                size_clr_valid_d  = 1'b0;
                rr_ptr_d          = (int'(winner_q) == N - 1) ? '0 : winner_q + 1'b1;
                state_d           = DONE;
                case (op_q)
                    OP_ALLOC: begin
                        if (top_q != '0 || allocs_q < W'(NArrays)) begin
                            // Reuse freed handles (LIFO) before fresh ones.
                            if (top_q != '0) top_d    = top_q - 1'b1;
                            else             allocs_d = allocs_q + 1'b1;
                            for (int j = 0; j < NArrays; j++)
                                if (new_idx == W'(j)) live_d[j] = 1'b1;
                            resp_index_d     = new_idx;
                            size_clr_valid_d = 1'b1;
                            size_clr_index_d = new_idx;
                            in_use_d         = in_use_q + 1'b1;
                        end else begin
                            resp_error_d = 1'b1;
                            resp_index_d = '0;
                        end
                    end
                    OP_FREE: begin
                        resp_index_d = idx_q;
                        if (idx_q < allocs_q && live_hit) begin
                            // A push needs a live bit, so the stack never overflows.
                            for (int j = 0; j < NArrays; j++) begin
                                if (top_q == TW'(j)) stack_d[j] = idx_q;
                                if (idx_q == W'(j))  live_d[j]  = 1'b0;
                            end
                            top_d    = top_q + 1'b1;
                            in_use_d = in_use_q - 1'b1;
                        end else begin
                            resp_error_d = 1'b1;
                        end
                    end
                    default: begin
                        resp_error_d = 1'b1;
                        resp_index_d = '0;
                    end
                endcase
            end
            default: begin
                grant_d          = '0;
                resp_valid_d     = 1'b0;
                resp_error_d     = 1'b0;
                size_clr_valid_d = 1'b0;
                state_d          = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            op_q             <= OP_ALLOC;
            winner_q         <= '0;
            rr_ptr_q         <= '0;
            idx_q            <= '0;
            allocs_q         <= '0;
            in_use_q         <= '0;
            live_q           <= '0;
            for (int j = 0; j < NArrays; j++) stack_q[j] <= '0;
            top_q            <= '0;
            grant_q          <= '0;
            resp_valid_q     <= 1'b0;
            resp_index_q     <= '0;
            resp_error_q     <= 1'b0;
            size_clr_valid_q <= 1'b0;
            size_clr_index_q <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            winner_q         <= winner_d;
            rr_ptr_q         <= rr_ptr_d;
            idx_q            <= idx_d;
            allocs_q         <= allocs_d;
            in_use_q         <= in_use_d;
            live_q           <= live_d;
            stack_q          <= stack_d;
            top_q            <= top_d;
            grant_q          <= grant_d;
            resp_valid_q     <= resp_valid_d;
            resp_index_q     <= resp_index_d;
            resp_error_q     <= resp_error_d;
            size_clr_valid_q <= size_clr_valid_d;
            size_clr_index_q <= size_clr_index_d;
        end
    end

    assign grant          = grant_q;
    assign resp_valid     = resp_valid_q;
    assign resp_index     = resp_index_q;
    assign resp_error     = resp_error_q;
    assign size_clr_valid = size_clr_valid_q;
    assign size_clr_index = size_clr_index_q;
    assign allocs         = allocs_q;
    assign in_use         = in_use_q;
endmodule
